// File: rtl/video_timing_if.sv
// Bundle between the raster timing generator and its consumers: pixel-rate
// controls in, counts and decoded timing flags out.
interface video_timing_if #(
   parameter int CNT_W = 11
);
   logic             pixEn;
   logic             resync;
   logic [CNT_W-1:0] hCount;
   logic [CNT_W-1:0] vCount;
   logic             hVisible;
   logic             vVisible;
   logic             de;
   logic             hSync;
   logic             vSync;
   logic             lineStart;
   logic             frameStart;

   modport master (
      input  pixEn, resync,
      output hCount, vCount, hVisible, vVisible, de, hSync, vSync, lineStart, frameStart
   );

   modport slave (
      output pixEn, resync,
      input  hCount, vCount, hVisible, vVisible, de, hSync, vSync, lineStart, frameStart
   );
endinterface

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster timing generator. Counts and every decoded flag
// are registered together from the next-state counts, so they never skew.
module video_timing_gen #(
   parameter int H_VISIBLE  = 800,
   parameter int H_FRONT    = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BACK     = 88,
   parameter int V_VISIBLE  = 600,
   parameter int V_FRONT    = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BACK     = 23,
   parameter int H_SYNC_POL = 1,
   parameter int V_SYNC_POL = 0,
   parameter int CNT_W      = 11
) (
   input logic            clk,
   input logic            rstN,
   video_timing_if.master vt
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic             H_POL      = (H_SYNC_POL != 0);
   localparam logic             V_POL      = (V_SYNC_POL != 0);

   if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_width_check
      $error("CNT_W too narrow for the configured raster");
   end
   if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_porch_check
      $error("porch and sync widths must be at least 1");
   end

   function automatic logic in_window(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (c >= lo) && (c < hi);
   endfunction

   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

   logic [CNT_W-1:0] h_cnt_p0, v_cnt_p0;
   logic [CNT_W-1:0] h_cnt_p1, v_cnt_p1;
   logic             vld_p0;
   logic             h_vis_p1, v_vis_p1, de_p1, h_sync_p1, v_sync_p1;
   logic             line_start_p1, frame_start_p1;

   // Stage p0: next raster position; resync beats the normal advance
   assign vld_p0 = vt.pixEn;

   always_comb begin
      h_cnt_p0 = h_cnt_p1 + ONE;
      v_cnt_p0 = v_cnt_p1;
      if (vt.resync) begin
         h_cnt_p0 = '0;
         v_cnt_p0 = '0;
      end else if (h_cnt_p1 == H_LAST) begin
         h_cnt_p0 = '0;
         v_cnt_p0 = (v_cnt_p1 == V_LAST) ? '0 : v_cnt_p1 + ONE;
      end
   end

   // Stage p1: counts and flags decoded from the same next-state values
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         h_cnt_p1       <= '0;
         v_cnt_p1       <= '0;
         h_vis_p1       <= 1'b1;
         v_vis_p1       <= 1'b1;
         de_p1          <= 1'b1;
         h_sync_p1      <= ~H_POL;
         v_sync_p1      <= ~V_POL;
         line_start_p1  <= 1'b1;
         frame_start_p1 <= 1'b1;
      end else if (vld_p0) begin
         h_cnt_p1       <= h_cnt_p0;
         v_cnt_p1       <= v_cnt_p0;
         h_vis_p1       <= (h_cnt_p0 < H_VIS_END);
         v_vis_p1       <= (v_cnt_p0 < V_VIS_END);
         de_p1          <= (h_cnt_p0 < H_VIS_END) && (v_cnt_p0 < V_VIS_END);
         h_sync_p1      <= sync_level(in_window(h_cnt_p0, H_SYNC_BEG, H_SYNC_END), H_POL);
         v_sync_p1      <= sync_level(in_window(v_cnt_p0, V_SYNC_BEG, V_SYNC_END), V_POL);
         line_start_p1  <= (h_cnt_p0 == '0);
         frame_start_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      end
   end

   assign vt.hCount     = h_cnt_p1;
   assign vt.vCount     = v_cnt_p1;
   assign vt.hVisible   = h_vis_p1;
   assign vt.vVisible   = v_vis_p1;
   assign vt.de         = de_p1;
   assign vt.hSync      = h_sync_p1;
   assign vt.vSync      = v_sync_p1;
   assign vt.lineStart  = line_start_p1;
   assign vt.frameStart = frame_start_p1;
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised horizontal and vertical raster timing generator for the display pipeline. It owns both the pixel counter and the line counter. It produces visible, sync, data-enable and start-of-line/frame strobes, all registered and aligned with the counts they describe. It replaces the standalone per-axis sync decoders. Downstream pixel-fetch and DAC/HDMI output logic consume its outputs directly.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BACK, 88, horizontal back porch (pixels)
V_VISIBLE, 600, visible lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BACK, 23, vertical back porch (lines)
H_SYNC_POL, 1, hSync level while asserted (1 = active-high)
V_SYNC_POL, 0, vSync level while asserted (0 = active-low)
CNT_W, 11, width of hCount/vCount

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
pixEn  in  1  pixel-rate enable; all state advances only when high
resync  in  1  synchronous restart to (0,0) on next pixEn cycle
hCount  out  CNT_W  current pixel index, 0..H_TOTAL-1
vCount  out  CNT_W  current line index, 0..V_TOTAL-1
hVisible  out  1  hCount < H_VISIBLE
vVisible  out  1  vCount < V_VISIBLE
de  out  1  hVisible & vVisible
hSync  out  1  horizontal sync, polarity per H_SYNC_POL
vSync  out  1  vertical sync, polarity per V_SYNC_POL
lineStart  out  1  one-pixEn-cycle strobe at hCount==0
frameStart  out  1  one-pixEn-cycle strobe at hCount==0 && vCount==0

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is asynchronous and active-low.
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Defaults give 1056 x 628 (SVGA 800x600@60).
- Sync windows:
  - hSync asserted for H_VISIBLE+H_FRONT <= hCount < H_VISIBLE+H_FRONT+H_SYNC.
  - vSync asserted for V_VISIBLE+V_FRONT <= vCount < V_VISIBLE+V_FRONT+V_SYNC.
- Reset (rstN low, async):
  - hCount=0, vCount=0.
  - hVisible=1, vVisible=1, de=1.
  - hSync=!H_SYNC_POL, vSync=!V_SYNC_POL.
  - lineStart=1, frameStart=1.
  - Outputs therefore describe position (0,0) immediately after reset.
- Every output is a flop. Decode is computed from next-state counts, so flags are valid in the same cycle as the count they describe. No combinational path from counters to outputs; zero-cycle skew between count and flags.
- On a clk edge with pixEn=1 and resync=0:
  - hCount wraps H_TOTAL-1 -> 0, otherwise increments.
  - vCount increments only when hCount wraps, and wraps V_TOTAL-1 -> 0.
- pixEn=0: all outputs hold, including strobes. Strobes are qualified by pixEn downstream; they stay asserted while pixEn is low.
- resync=1 with pixEn=1: next state is (0,0) with reset-equivalent flags; frameStart and lineStart assert.
- resync=1 with pixEn=0: ignored.
- resync has priority over normal advance.
- Boundary conditions:
  - Last pixel of frame (H_TOTAL-1, V_TOTAL-1) -> (0,0) in one pixEn cycle, frameStart=1.
  - Last pixel of line (H_TOTAL-1, n) -> (0, n+1), lineStart=1, frameStart=0.
  - Sync windows are half-open as defined above. hSync therefore spans exactly H_SYNC pixEn cycles and vSync exactly V_SYNC lines (V_SYNC*H_TOTAL cycles).
- Width rules: CNT_W must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL). Compare constants are sized to CNT_W; no truncation is permitted. All porch and sync parameters must be >= 1; zero-width porches are unsupported.
- Reset deasserted mid-frame: counting resumes from (0,0) on the first pixEn cycle after rstN rises.

Test Plan:
- Reset check: hold rstN=0 for 3 cycles with pixEn=1 -> hCount=0, vCount=0, de=1, hSync=0, vSync=1, frameStart=1. Release -> next pixEn cycle gives hCount=1, frameStart=0, lineStart=0.
- Small-raster timing: H=4/1/2/1 (total 8), V=3/1/1/1 (total 6), pixEn=1 continuously.
  - hSync=1 exactly at hCount 5,6.
  - vSync=0 exactly on line 4 (8 cycles).
  - de high 12 cycles per frame.
  - frameStart every 48 cycles.
- Wrap: run default params to hCount=1055, vCount=627 -> next cycle (0,0) with frameStart=1, vVisible=1, vSync=1.
- Enable gating: pixEn toggling 1,0,0,1 -> counts advance only on pixEn=1 cycles; outputs stable across the pixEn=0 cycles.
- Resync: assert resync with pixEn=1 at (300,450) -> next cycle (0,0), frameStart=1. Repeat with pixEn=0 -> no change.
- Async reset mid-frame: drop rstN between clk edges at (517,33) -> outputs reach reset values before the next clk edge.
